// File: rtl/narrow_mem_bridge.sv
// Bridges one wide core request/response onto a narrow lane-serial external bus.
// Writes stream Beats lanes out; reads send one address beat and then collect Beats lanes.
module narrow_mem_bridge #(
  parameter int DataWidth = 32,
  parameter int LaneWidth = 4,
  parameter int AddrWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  input  logic                   req_write_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [AddrWidth-1:0]   ext_addr_o,
  output logic [LaneWidth-1:0]   ext_data_o,
  output logic                   ext_strb_o,
  output logic                   ext_write_o,
  output logic                   ext_valid_o,
  input  logic                   ext_ready_i,
  input  logic [LaneWidth-1:0]   ext_data_i,
  input  logic                   ext_rvalid_i,
  output logic                   ext_rready_o
);

  localparam int Beats     = DataWidth / LaneWidth;
  localparam int StrbWidth = DataWidth / 8;
  localparam int CntWidth  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Beats - 1);

  typedef enum logic [2:0] {
    IDLE,
    WSEND,
    RADDR,
    RRECV,
    RSP
  } state_e;

  state_e                           state_q, state_d;
  logic [CntWidth-1:0]              cnt_q, cnt_d;
  logic [AddrWidth-1:0]             addr_q, addr_d;
  logic [Beats-1:0][LaneWidth-1:0]  wdata_q, wdata_d;
  logic [StrbWidth-1:0]             strb_q, strb_d;
  logic                             write_q, write_d;
  logic [Beats-1:0][LaneWidth-1:0]  rdata_q, rdata_d;
  logic [Beats-1:0]                 lane_strb;
  logic                             last_beat;

  // Each lane inherits the strobe of the byte that contains it.
  always_comb begin
    lane_strb = '0;
    for (int i = 0; i < Beats; i++) begin
      lane_strb[i] = strb_q[(i * LaneWidth) / 8];
    end
  end

  assign last_beat = (cnt_q == LastBeat);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          strb_d  = req_strb_i;
          write_d = req_write_i;
          cnt_d   = '0;
          rdata_d = '0;
          state_d = req_write_i ? WSEND : RADDR;
        end
      end
      WSEND: begin
        if (ext_ready_i) begin
          cnt_d = last_beat ? '0 : cnt_q + CntWidth'(1);
          if (last_beat) begin
            state_d = RSP;
          end
        end
      end
      RADDR: begin
        if (ext_ready_i) begin
          state_d = RRECV;
        end
      end
      RRECV: begin
        if (ext_rvalid_i) begin
          rdata_d[cnt_q] = ext_data_i;
          cnt_d = last_beat ? '0 : cnt_q + CntWidth'(1);
          if (last_beat) begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs depend only on registered state, so no input reaches an output combinationally.
  assign req_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RSP);
  assign rsp_rdata_o  = rdata_q;
  assign ext_addr_o   = addr_q;
  assign ext_write_o  = write_q;
  assign ext_valid_o  = (state_q == WSEND) || (state_q == RADDR);
  assign ext_data_o   = (state_q == WSEND) ? wdata_q[cnt_q] : '0;
  assign ext_strb_o   = (state_q == WSEND) ? lane_strb[cnt_q] : 1'b0;
  assign ext_rready_o = (state_q == RRECV);

endmodule

// File: doc/narrow_mem_bridge.md
NARROW_MEM_BRIDGE -- requirements
Module: narrow_mem_bridge

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of core request/response data.
REQ-002 SHALL have parameter LaneWidth, default 4, width of external data lane; legal values 1, 2, 4, 8; DataWidth % 8 == 0.
REQ-003 SHALL have parameter AddrWidth, default 32, address width.
REQ-004 SHALL have clk  input  1  sole clock; all logic on rising edge; reset is synchronous and active-high.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have req_addr_i  input  AddrWidth  core request address.
REQ-007 SHALL have req_wdata_i  input  DataWidth  core write data.
REQ-008 SHALL have req_strb_i  input  DataWidth/8  byte write strobes.
REQ-009 SHALL have req_write_i  input  1  1=write, 0=read.
REQ-010 SHALL have req_valid_i / req_ready_o  input/output  1  core request handshake.
REQ-011 SHALL have rsp_rdata_o  output  DataWidth  read data (0 for writes).
REQ-012 SHALL have rsp_valid_o / rsp_ready_i  output/input  1  core response handshake.
REQ-013 SHALL have ext_addr_o  output  AddrWidth  captured transaction address.
REQ-014 SHALL have ext_data_o  output  LaneWidth  outgoing lane.
REQ-015 SHALL have ext_strb_o  output  1  strobe for current outgoing lane.
REQ-016 SHALL have ext_write_o  output  1  captured write flag.
REQ-017 SHALL have ext_valid_o / ext_ready_i  output/input  1  outgoing lane handshake.
REQ-018 SHALL have ext_data_i  input  LaneWidth  incoming read lane.
REQ-019 SHALL have ext_rvalid_i / ext_rready_o  input/output  1  incoming lane handshake.

Function
REQ-020 SHALL define Beats = DataWidth/LaneWidth; beat counter width clog2(Beats), wraps never (cleared on exit).
REQ-021 SHALL implement FSM IDLE, WSEND, RADDR, RRECV, RSP; all outputs driven from registers/state only (no input-to-output combinational path except none).
REQ-022 IDLE: req_ready_o=1; on req_valid_i capture addr, wdata, strb, write, clear counter and rdata register; go WSEND if write else RADDR.
REQ-023 WSEND: ext_valid_o=1, ext_data_o = wdata lane[cnt] (LSB lane first), ext_strb_o = strb[(cnt*LaneWidth)/8]; on ext_ready_i advance cnt; on beat Beats-1 accepted go RSP.
REQ-024 RADDR: ext_valid_o=1, ext_write_o=0, ext_data_o=0, ext_strb_o=0; on ext_ready_i go RRECV.
REQ-025 RRECV: ext_rready_o=1; each ext_rvalid_i writes ext_data_i into rdata lane[cnt], advances cnt; after beat Beats-1 go RSP.
REQ-026 RSP: rsp_valid_o=1, rsp_rdata_o held stable; on rsp_ready_i go IDLE.
REQ-027 ext_valid_o deasserted-stall (ext_ready_i=0) SHALL hold ext_data_o, ext_strb_o, cnt unchanged.
REQ-028 ext_rvalid_i outside RRECV SHALL be ignored; ext_rready_o=0 outside RRECV.
REQ-029 req_ready_o SHALL be 0 outside IDLE; only one transaction outstanding.
REQ-030 Latency with ready inputs held 1: write rsp_valid_o in cycle Beats+1 after acceptance; read rsp_valid_o in cycle Beats+2 (1 addr beat + Beats lanes).
REQ-031 ext_addr_o, ext_write_o SHALL stay constant from acceptance until return to IDLE.
REQ-032 All-zero strobe write SHALL still send all Beats lanes with ext_strb_o=0.

Reset
REQ-033 On rst=1 at a clock edge: state IDLE, cnt 0, all captured registers 0; next cycle req_ready_o=1, all other outputs 0.
REQ-034 rst mid-transaction SHALL abort it silently: no rsp_valid_o, partial lanes discarded.

Verification
REQ-035 Defaults, write 0xDEADBEEF strb 0xF, ext_ready_i=1 -> lanes F,E,E,B,D,A,E,D over 8 cycles, ext_strb_o all 1, rsp_valid_o cycle 9.
REQ-036 Write strb 0b0101 -> ext_strb_o per lane 1,1,0,0,1,1,0,0.
REQ-037 Read addr 0x100, ext_data_i lanes 1..8 with ext_rvalid_i gaps -> rsp_rdata_o=0x87654321, ext_addr_o=0x100 throughout.
REQ-038 ext_ready_i toggled 0/1 randomly during write -> no lane skipped/duplicated; rsp_rdata_o=0; rsp_ready_i=0 for 5 cycles holds rsp_valid_o.
REQ-039 rst asserted at beat 3 of a read -> IDLE next cycle, no response; subsequent write completes normally.
REQ-040 LaneWidth=8, DataWidth=64 -> 8 byte beats, strobe bit k per beat k.
